// File: rtl/sha256_compact.sv
// sha256_compact: iterative single-block SHA-256 compression, one round per clock.
// Every start hashes one pre-padded 512-bit block from the standard initial hash value.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous reset, active HIGH despite the name
//   start  - hash request, sampled while idle or done
//   block  - padded message block, block[511:480] = W0 ... block[31:0] = W15
//   digest - result, digest[255:224] = H0 ... digest[31:0] = H7
//   ready  - digest valid for the most recent start
module sha256_compact (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] block,
  output logic [255:0] digest,
  output logic         ready
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned WIN_N  = 16;
  localparam int unsigned CNT_W  = 7;
  // Counter value that selects the final-add cycle after round 63.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(64);

  localparam logic [WORD_W-1:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [WORD_W-1:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_e;

  function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  logic [WORD_W-1:0]   a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d;
  logic [WORD_W-1:0]   w_q [WIN_N];
  logic [WORD_W-1:0]   w_d [WIN_N];
  logic [255:0]        digest_q, digest_d;
  logic                ready_q, ready_d;
  logic [WORD_W-1:0]   t1, t2, w_tail;

  assign digest = digest_q;
  assign ready  = ready_q;

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
      e_q <= '0; f_q <= '0; g_q <= '0; h_q <= '0;
      for (int i = 0; i < WIN_N; i++) w_q[i] <= '0;
      digest_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
      e_q <= e_d; f_q <= f_d; g_q <= g_d; h_q <= h_d;
      for (int i = 0; i < WIN_N; i++) w_q[i] <= w_d[i];
      digest_q <= digest_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state logic; the ROUND state also covers the final-add cycle (cnt == 64).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_ROUND;
      S_ROUND:        if (cnt_q == LAST_CNT) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Round datapath, message schedule, and final add.
  always_comb begin
    t1     = h_q + big_sigma1(e_q) + ((e_q & f_q) ^ (~e_q & g_q)) + K[cnt_q[5:0]] + w_q[0];
    t2     = big_sigma0(a_q) + ((a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q));
    w_tail = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

    cnt_d    = cnt_q;
    a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q;
    e_d = e_q; f_d = f_q; g_d = g_q; h_d = h_q;
    for (int i = 0; i < WIN_N; i++) w_d[i] = w_q[i];
    digest_d = digest_q;
    ready_d  = ready_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          for (int i = 0; i < WIN_N; i++) w_d[i] = block[511 - 32*i -: 32];
          a_d = H0[0]; b_d = H0[1]; c_d = H0[2]; d_d = H0[3];
          e_d = H0[4]; f_d = H0[5]; g_d = H0[6]; h_d = H0[7];
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      end
      S_ROUND: begin
        if (cnt_q == LAST_CNT) begin
          digest_d = {H0[0] + a_q, H0[1] + b_q, H0[2] + c_q, H0[3] + d_q,
                      H0[4] + e_q, H0[5] + f_q, H0[6] + g_q, H0[7] + h_q};
          ready_d  = 1'b1;
        end else begin
          h_d = g_q; g_d = f_q; f_d = e_q; e_d = d_q + t1;
          d_d = c_q; c_d = b_q; b_d = a_q; a_d = t1 + t2;
          for (int i = 0; i < WIN_N - 1; i++) w_d[i] = w_q[i+1];
          w_d[WIN_N-1] = w_tail;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sha256_compact.sv
// Directed testbench for sha256_compact using known SHA-256 vectors.
module tb_sha256_compact;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [255:0] ABC_DIG   =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam int LIMIT = 200;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [511:0] block;
  logic [255:0] digest;
  logic         ready;

  int checks;
  int errors;

  sha256_compact dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .block  (block),
    .digest (digest),
    .ready  (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present blk with start high for exactly one sampling edge; returns #1 after that edge.
  task automatic issue_start(input logic [511:0] blk);
    @(negedge clk);
    block = blk;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    block = '0;
  endtask

  // Count edges after the start edge until ready is seen high (bounded).
  task automatic wait_ready(output int n);
    n = 0;
    while (n < LIMIT) begin
      @(posedge clk);
      #1;
      n++;
      if (ready === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    block = ABC_BLK;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b0) begin
        errors++; $display("FAIL reset_ready cyc %0d: got %b want 0", i, ready);
      end
      checks++;
      if (digest !== 256'h0) begin
        errors++; $display("FAIL reset_digest cyc %0d: got %h want 0", i, digest);
      end
    end
    @(negedge clk);
    start = 1'b0;
    block = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL reset_idle_ready: got %b want 0", ready);
    end
  endtask

  task automatic test_abc();
    int n;
    issue_start(ABC_BLK);
    wait_ready(n);
    checks++;
    if (n !== 65) begin
      errors++; $display("FAIL abc_latency: got %0d want 65", n);
    end
    checks++;
    if (digest !== ABC_DIG) begin
      errors++; $display("FAIL abc_digest: got %h want %h", digest, ABC_DIG);
    end
  endtask

  task automatic test_empty();
    int n;
    repeat (4) @(posedge clk);
    issue_start(EMPTY_BLK);
    wait_ready(n);
    checks++;
    if (n !== 65) begin
      errors++; $display("FAIL empty_latency: got %0d want 65", n);
    end
    checks++;
    if (digest !== EMPTY_DIG) begin
      errors++; $display("FAIL empty_digest: got %h want %h", digest, EMPTY_DIG);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1 || digest !== EMPTY_DIG) begin
      errors++; $display("FAIL empty_hold: got ready %b digest %h want 1 %h", ready, digest, EMPTY_DIG);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit early;
    issue_start(ABC_BLK);
    wait_ready(n);
    checks++;
    if (digest !== ABC_DIG) begin
      errors++; $display("FAIL b2b_first_digest: got %h want %h", digest, ABC_DIG);
    end
    // Start the next hash on the very next edge after ready rises.
    block = EMPTY_BLK;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    block = '0;
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL b2b_ready_drop: got %b want 0", ready);
    end
    n = 0;
    early = 1'b0;
    while (n < LIMIT) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 30) begin
        checks++;
        if (digest !== ABC_DIG) begin
          errors++; $display("FAIL b2b_digest_held: got %h want %h", digest, ABC_DIG);
        end
      end
      if (ready === 1'b1) break;
    end
    checks++;
    if (n !== 65) begin
      errors++; $display("FAIL b2b_latency: got %0d want 65", n);
    end
    checks++;
    if (digest !== EMPTY_DIG) begin
      errors++; $display("FAIL b2b_second_digest: got %h want %h", digest, EMPTY_DIG);
    end
  endtask

  task automatic test_busy_start();
    int n;
    repeat (3) @(posedge clk);
    issue_start(ABC_BLK);
    n = 0;
    while (n < LIMIT) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 20) begin
        start = 1'b1;
        block = EMPTY_BLK;
      end
      if (n == 21) begin
        start = 1'b0;
        block = '0;
      end
      if (ready === 1'b1) break;
    end
    checks++;
    if (n !== 65) begin
      errors++; $display("FAIL busy_latency: got %0d want 65", n);
    end
    checks++;
    if (digest !== ABC_DIG) begin
      errors++; $display("FAIL busy_digest: got %h want %h", digest, ABC_DIG);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    repeat (3) @(posedge clk);
    issue_start(EMPTY_BLK);
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL midrst_ready: got %b want 0", ready);
    end
    checks++;
    if (digest !== 256'h0) begin
      errors++; $display("FAIL midrst_digest: got %h want 0", digest);
    end
    // An abandoned hash must not complete later.
    repeat (60) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0 || digest !== 256'h0) begin
      errors++; $display("FAIL midrst_idle: got ready %b digest %h want 0 0", ready, digest);
    end
    issue_start(ABC_BLK);
    wait_ready(n);
    checks++;
    if (n !== 65) begin
      errors++; $display("FAIL midrst_latency: got %0d want 65", n);
    end
    checks++;
    if (digest !== ABC_DIG) begin
      errors++; $display("FAIL midrst_digest_after: got %h want %h", digest, ABC_DIG);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    start  = 1'b0;
    block  = '0;
    test_reset();
    test_abc();
    test_empty();
    test_back_to_back();
    test_busy_start();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_compact.md
Name: sha256_compact

Overview:
Iterative single-block SHA-256 compression core computing one round per clock. It accepts one pre-padded 512-bit message block and returns the 256-bit digest of that block, starting from the standard initial hash value (FIPS 180-4). Intended as a compact hashing engine. Padding and multi-block chaining are done by the caller or upstream logic.

Parameters:
None. All constants (H0 initial values, K[0..63]) are fixed per FIPS 180-4.

Ports:
clk     input   1    rising-edge clock; only clock in the block
rst_n   input   1    reset, synchronous and active-high (asserted when 1 despite the name)
start   input   1    request to hash `block`, sampled on rising clk
block   input   512  padded message block; block[511:480]=W0 … block[31:0]=W15, big-endian words
digest  output  256  result; digest[255:224]=H0 … digest[31:0]=H7
ready   output  1    level: digest valid for the most recent start

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - FSM goes to IDLE.
  - ready=0, digest=0.
  - Round counter, working registers a..h and the W window are cleared.
  - Reset overrides start, including mid-hash; a hash in progress is abandoned.
- FSM states are IDLE, ROUND and DONE.
- IDLE or DONE with start=1 at edge N:
  - Latch block into a 16×32 W window.
  - Load a..h with H0: 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19.
  - Set t=0, set ready<=0, go to ROUND.
  - digest keeps its previous value until overwritten.
- ROUND: one round per edge (edges N+1..N+64, t=0..63).
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W_t
  - T2 = Σ0(a) + Maj(a,b,c)
  - h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2
  - All additions are mod 2^32.
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25.
  - Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).
  - W_t is the window head (window[0]).
  - Window shifts left by one each round. The new tail = σ1(W[14]) + W[9] + σ0(W[1]) + W[0].
  - σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
  - After round t=63, go to final add.
- Final add at edge N+65:
  - digest <= {H0_i + reg_i} for i=a..h, each mod 2^32.
  - ready <= 1; go to DONE.
- Total latency is 65 clocks from the start sample edge to ready high.
- DONE: ready stays 1 and digest is held until the next start or reset.
- start is ignored while in ROUND or final add; the block input is not re-sampled there.
- start held high continuously restarts a new hash each time DONE is reached.
- block only needs to be stable at the start-sample edge.
- No multi-block chaining: every start begins from H0.

Test Plan:
- Reset hold: rst_n=1 for 2 clks with start=1 -> ready=0, digest=0, no hash begins.
- "abc": block=61626380 followed by zeros, last word 00000018, start pulsed one clk -> ready rises exactly 65 clks after the sample edge; digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty message: block=80000000 followed by all zeros, start -> digest=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- Back-to-back: after "abc" completes, start with the empty block -> ready drops the clk after start; new digest appears 65 clks later; ready stays low in between.
- Busy start ignored: pulse start with a different block at round 20 of a hash -> result still equals the first block's digest; latency unchanged.
- Mid-hash reset: assert rst_n at round 30 -> ready=0, digest=0, FSM IDLE; a subsequent "abc" start yields the correct digest.
